// File: rtl/fc1_bias_add.sv
// fc1 bias join: aligns bias to the accumulator format, adds per lane, requantises (round/saturate).
// Optional round-half-up requantisation when FC1_BIAS_ADD_ROUND_EN is defined (floor otherwise).
module fc1_bias_add #(
    parameter int unsigned DATA_IN_PRECISION_0  = 32,
    parameter int unsigned DATA_IN_PRECISION_1  = 6,
    parameter int unsigned BIAS_PRECISION_0     = 16,
    parameter int unsigned BIAS_PRECISION_1     = 3,
    parameter int unsigned DATA_OUT_PRECISION_0 = 16,
    parameter int unsigned DATA_OUT_PRECISION_1 = 4,
    parameter int unsigned TENSOR_SIZE_DIM_0    = 32,
    parameter int unsigned PARALLELISM_DIM_0    = 1,
    parameter int unsigned OUT_DEPTH            = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [DATA_IN_PRECISION_0*PARALLELISM_DIM_0-1:0]  data_in,
    input  logic                                              data_in_valid,
    output logic                                              data_in_ready,
    input  logic [BIAS_PRECISION_0*PARALLELISM_DIM_0-1:0]     bias,
    input  logic                                              bias_valid,
    output logic                                              bias_ready,
    output logic [DATA_OUT_PRECISION_0*PARALLELISM_DIM_0-1:0] data_out,
    output logic                                              data_out_valid,
    input  logic                                              data_out_ready,
    output logic                                              data_out_last
);

    localparam int DIN_W  = DATA_IN_PRECISION_0;
    localparam int BIAS_W = BIAS_PRECISION_0;
    localparam int DOUT_W = DATA_OUT_PRECISION_0;
    localparam int PAR    = PARALLELISM_DIM_0;
    localparam int BSH    = DATA_IN_PRECISION_1 - BIAS_PRECISION_1;
    localparam int SH     = DATA_IN_PRECISION_1 - DATA_OUT_PRECISION_1;
    localparam int SUM_W  = ((DIN_W > BIAS_W + BSH) ? DIN_W : BIAS_W + BSH) + 1;
    localparam int CW     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
`ifdef FC1_BIAS_ADD_ROUND_EN
    localparam int QW = SUM_W + 1;
    localparam logic signed [QW-1:0] RND = (SH > 0) ? (QW'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
`else
    localparam int QW = SUM_W;
`endif
    localparam logic signed [QW-1:0] OMAX = (QW'(1) << (DOUT_W - 1)) - QW'(1);
    localparam logic signed [QW-1:0] OMIN = -(QW'(1) << (DOUT_W - 1));
    localparam logic [DOUT_W-1:0] SAT_HI = {1'b0, {(DOUT_W - 1){1'b1}}};
    localparam logic [DOUT_W-1:0] SAT_LO = {1'b1, {(DOUT_W - 1){1'b0}}};
    localparam logic [CW-1:0] CNT_LAST = CW'(OUT_DEPTH - 1);

    logic                    s1_valid_q, s1_valid_d;
    logic                    dout_valid_q, dout_valid_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DOUT_W*PAR-1:0]   dout_q, dout_d, sat;
    logic signed [SUM_W-1:0] sum_q [PAR];
    logic signed [SUM_W-1:0] sum_d [PAR];
    logic signed [QW-1:0]    q;
    logic                    s1_ready, s2_ready, join_ok, s1_fire, s2_load, out_fire;

    // Join: neither stream is acknowledged unless both are valid, and never during reset.
    always_comb begin
        s2_ready      = !dout_valid_q || data_out_ready;
        s1_ready      = !s1_valid_q || s2_ready;
        join_ok       = rst && s1_ready;
        data_in_ready = bias_valid && join_ok;
        bias_ready    = data_in_valid && join_ok;
        s1_fire       = data_in_valid && bias_valid && join_ok;
        s2_load       = s1_valid_q && s2_ready;
        out_fire      = dout_valid_q && data_out_ready;
    end

    always_comb begin
        for (int l = 0; l < PAR; l++) begin
            sum_d[l] = SUM_W'(signed'(data_in[l*DIN_W +: DIN_W]))
                     + (SUM_W'(signed'(bias[l*BIAS_W +: BIAS_W])) <<< BSH);
        end
    end

    always_comb begin
        sat = '0;
        q   = '0;
        for (int l = 0; l < PAR; l++) begin
`ifdef FC1_BIAS_ADD_ROUND_EN
            q = (QW'(sum_q[l]) + RND) >>> SH;
`else
            q = sum_q[l] >>> SH;
`endif
            if (q > OMAX) begin
                sat[l*DOUT_W +: DOUT_W] = SAT_HI;
            end else if (q < OMIN) begin
                sat[l*DOUT_W +: DOUT_W] = SAT_LO;
            end else begin
                sat[l*DOUT_W +: DOUT_W] = q[DOUT_W-1:0];
            end
        end
    end

    always_comb begin
        s1_valid_d   = s1_fire || (s1_valid_q && !s2_ready);
        dout_valid_d = s2_ready ? s1_valid_q : dout_valid_q;
        dout_d       = s2_load ? sat : dout_q;
        cnt_d        = cnt_q;
        if (out_fire) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            cnt_q        <= '0;
            dout_q       <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            dout_valid_q <= dout_valid_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_fire) begin
            for (int l = 0; l < PAR; l++) begin
                sum_q[l] <= sum_d[l];
            end
        end
    end

    assign data_out       = dout_q;
    assign data_out_valid = dout_valid_q;
    assign data_out_last  = dout_valid_q && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_fc1_bias_add.sv
// Self-checking bench for fc1_bias_add: directed beats plus a randomized backpressured stream.
module tb_fc1_bias_add;

    localparam int DEPTH  = 32;
    localparam int NBEATS = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic [15:0] bias = '0;
    logic        bias_valid = 1'b0;
    logic        bias_ready;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready = 1'b1;
    logic        data_out_last;

    fc1_bias_add dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .bias           (bias),
        .bias_valid     (bias_valid),
        .bias_ready     (bias_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out_last  (data_out_last)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          exp_q[$];
    int          n_in = 0;
    int          n_out = 0;
    int          n_last = 0;
    int          held = 0;
    logic        in_fire = 1'b0;
    logic        out_fire = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_last = 1'b0;
    logic [15:0] prev_dout = '0;

    // Reference: value = d/64 + b/8, output in 1/16 units, then round/floor and clamp.
    function automatic int model(int d, int b);
        longint s;
        s = longint'(d) + longint'(b) * 8;
`ifdef FC1_BIAS_ADD_ROUND_EN
        s = s + 2;
`endif
        s = s >>> 2;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at negedge, update scoreboard, return 1ns after posedge.
    task automatic cycle();
        @(negedge clk);
        in_fire  = data_in_valid && bias_valid && data_in_ready;
        out_fire = data_out_valid && data_out_ready;
        if (prev_stall) begin
            check("stall_valid", int'(data_out_valid), 1);
            check("stall_data", int'(data_out), int'(prev_dout));
            check("stall_last", int'(data_out_last), int'(prev_last));
        end
        if (rst && bias_valid)
            check("data_in_ready", int'(data_in_ready), int'(held < 2 || data_out_ready));
        if (rst && data_in_valid)
            check("bias_ready", int'(bias_ready), int'(held < 2 || data_out_ready));
        if (out_fire) begin
            if (exp_q.size() == 0) check("unexpected_output", 1, 0);
            else check("data_out", int'($signed(data_out)), exp_q.pop_front());
            check("data_out_last", int'(data_out_last), int'((n_out % DEPTH) == DEPTH - 1));
            if (data_out_last) n_last++;
            n_out++;
        end
        if (in_fire) begin
            exp_q.push_back(model(int'($signed(data_in)), int'($signed(bias))));
            n_in++;
        end
        held       = held + int'(in_fire) - int'(out_fire);
        prev_stall = data_out_valid && !data_out_ready;
        prev_dout  = data_out;
        prev_last  = data_out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic one_beat(string tag, int d, int b, int exp);
        int n0;
        n0            = n_in;
        data_in       = d;
        bias          = 16'(b);
        data_in_valid = 1'b1;
        bias_valid    = 1'b1;
        cycle();
        data_in_valid = 1'b0;
        bias_valid    = 1'b0;
        check({tag, "_fired"}, n_in, n0 + 1);
        check({tag, "_lat1"}, int'(data_out_valid), 0);
        cycle();
        check({tag, "_valid"}, int'(data_out_valid), 1);
        check(tag, int'($signed(data_out)), exp);
        cycle();
    endtask

    task automatic rand_beat();
        data_in = 32'(int'($urandom_range(0, 2000000)) - 1000000);
        bias    = 16'(int'($urandom_range(0, 40000)) - 20000);
    endtask

    task automatic stream(int nbeats, bit rand_ready);
        int sent;
        int target;
        sent   = 0;
        target = n_out + nbeats;
        rand_beat();
        data_in_valid  = 1'b1;
        bias_valid     = 1'b1;
        data_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 0; c < 4000 && n_out < target; c++) begin
            cycle();
            if (in_fire) begin
                sent++;
                if (sent < nbeats) rand_beat();
                else begin
                    data_in_valid = 1'b0;
                    bias_valid    = 1'b0;
                end
            end
            data_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        data_in_valid  = 1'b0;
        bias_valid     = 1'b0;
        data_out_ready = 1'b1;
        check("stream_beats_out", n_out, target);
    endtask

    initial begin
        // Reset with both inputs valid: readies must stay low.
        data_in_valid = 1'b1;
        bias_valid    = 1'b1;
        cycle();
        cycle();
        check("rst_din_ready", int'(data_in_ready), 0);
        check("rst_bias_ready", int'(bias_ready), 0);
        check("rst_valid", int'(data_out_valid), 0);
        check("rst_last", int'(data_out_last), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_no_fire", n_in, 0);
        data_in_valid = 1'b0;
        bias_valid    = 1'b0;
        rst           = 1'b1;
        cycle();

        one_beat("basic", 64, 8, 32);
`ifdef FC1_BIAS_ADD_ROUND_EN
        one_beat("round_pos", 2, 0, 1);
        one_beat("round_neg", -2, 0, 0);
`else
        one_beat("round_pos", 2, 0, 0);
        one_beat("round_neg", -2, 0, -1);
`endif
        one_beat("sat_hi", 32'h7FFF_FFFF, 32'h7FFF, 32767);
        one_beat("sat_lo", 32'h8000_0000, 32'h8000, -32768);

        // Join skew: accumulator waits 3 cycles for bias.
        begin
            int n0;
            n0            = n_in;
            data_in       = 32'd100;
            bias          = 16'd5;
            data_in_valid = 1'b1;
            repeat (3) begin
                cycle();
                check("skew_din_ready", int'(data_in_ready), 0);
                check("skew_no_fire", n_in, n0);
            end
            bias_valid = 1'b1;
            cycle();
            data_in_valid = 1'b0;
            bias_valid    = 1'b0;
            check("skew_one_beat", n_in, n0 + 1);
            repeat (3) cycle();
            check("skew_one_beat_after", n_in, n0 + 1);
        end

        // Two beats in flight, stalled, then a one-cycle reset.
        data_out_ready = 1'b0;
        data_in_valid  = 1'b1;
        bias_valid     = 1'b1;
        repeat (2) begin
            rand_beat();
            cycle();
        end
        check("held_two_din_ready", int'(data_in_ready), 0);
        rst = 1'b0;
        #1;
        check("rstmid_din_ready", int'(data_in_ready), 0);
        check("rstmid_bias_ready", int'(bias_ready), 0);
        cycle();
        exp_q.delete();
        held       = 0;
        n_out      = 0;
        n_last     = 0;
        prev_stall = 1'b0;
        check("rstmid_valid", int'(data_out_valid), 0);
        check("rstmid_last", int'(data_out_last), 0);
        rst = 1'b1;
        #1;
        check("post_rst_din_ready", int'(data_in_ready), 1);
        check("post_rst_bias_ready", int'(bias_ready), 1);

        // Backpressured tensor: last on beat 31 only, then 24 more close the next tensor.
        stream(NBEATS, 1'b1);
        check("last_count_40", n_last, 1);
        stream(2 * DEPTH - NBEATS, 1'b0);
        check("last_count_64", n_last, 2);
        repeat (3) cycle();
        check("drained_valid", int'(data_out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
